// File: rtl/mem_access_pkg.sv
// Shared types and defaults for the MEM-stage access unit.
package mem_access_pkg;

    // Default geometry of the data memory interface
    localparam int ADDR_W_DEF  = 8;
    localparam int DATA_W_DEF  = 64;
    localparam int RD_W_DEF    = 5;
    localparam int TIMEOUT_DEF = 16;

    // Timeout counter width for the default timeout
    localparam int CNT_W_DEF = $clog2(TIMEOUT_DEF) + 1;

    // Transaction state: idle, or a request outstanding to memory
    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    // Counter width for an arbitrary timeout value
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout) + 1;
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts request cycles without acknowledge; expire flags the last
// cycle the request may stay outstanding (count == TIMEOUT-1).
module mem_timeout_counter
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = cnt_width(TIMEOUT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [CNT_W-1:0] count;

    assign expire = (count == CNT_W'(TIMEOUT - 1));

    // Count waiting cycles; saturate at the expire value
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: takes load/store/ALU ops from EX/MEM, runs a
// req/ack transaction to data memory, and pulses results to writeback.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RD_W    = RD_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_memread,
    input  logic              in_memwrite,
    input  logic [63:0]       in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [RD_W-1:0]   in_rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_regwrite,
    output logic              fault,
    output logic              stall
);

    state_t          state;
    state_t          state_next;
    logic            accept;
    logic            is_mem;
    logic            bad_op;
    logic            start_req;
    logic            expire;
    logic [RD_W-1:0] req_rd;

    assign accept = in_valid && in_ready;
    assign is_mem = in_memread || in_memwrite;
    // The address range check only applies to memory ops: for ALU ops
    // in_addr is a result value, not an address.
    assign bad_op = (in_memread && in_memwrite) ||
                    (is_mem && ((in_addr >> ADDR_W) != 64'd0));
    assign start_req = accept && is_mem && !bad_op;
    assign stall     = in_valid && !in_ready;

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (start_req),
        .enable ((state == REQ) && !mem_ack),
        .expire (expire)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: enter REQ on a legal memory op, leave on ack or timeout
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE: if (start_req) state_next = REQ;
            REQ:  if (mem_ack || expire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State-decoded outputs; mem_req falls as soon as reset clears the state
    always_comb begin
        in_ready = (state == IDLE);
        mem_req  = (state == REQ);
    end

    // Request latches and writeback result/fault pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            req_rd       <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_rd       <= '0;
            out_regwrite <= 1'b0;
            fault        <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            fault     <= 1'b0;
            if (accept) begin
                if (bad_op) begin
                    out_valid    <= 1'b1;
                    fault        <= 1'b1;
                    out_data     <= '0;
                    out_rd       <= in_rd;
                    out_regwrite <= 1'b0;
                end else if (!is_mem) begin
                    out_valid    <= 1'b1;
                    out_data     <= DATA_W'(in_addr);
                    out_rd       <= in_rd;
                    out_regwrite <= (in_rd != '0);
                end else begin
                    mem_we    <= in_memwrite;
                    mem_addr  <= in_addr[ADDR_W-1:0];
                    mem_wdata <= in_wdata;
                    req_rd    <= in_rd;
                end
            end else if (state == REQ) begin
                // Ack on the expiring edge still completes normally
                if (mem_ack) begin
                    out_valid    <= 1'b1;
                    out_rd       <= req_rd;
                    out_data     <= mem_we ? '0 : mem_rdata;
                    out_regwrite <= !mem_we && (req_rd != '0);
                end else if (expire) begin
                    out_valid    <= 1'b1;
                    fault        <= 1'b1;
                    out_data     <= '0;
                    out_rd       <= req_rd;
                    out_regwrite <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a vector table of single ops plus
// hand-written timeout, reset and back-to-back sequences.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_memread;
    logic        in_memwrite;
    logic [63:0] in_addr;
    logic [63:0] in_wdata;
    logic [4:0]  in_rd;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        out_valid;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
    logic        out_regwrite;
    logic        fault;
    logic        stall;

    int errors = 0;
    int checks = 0;

    mem_access_unit #(
        .ADDR_W  (8),
        .DATA_W  (64),
        .RD_W    (5),
        .TIMEOUT (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_memread   (in_memread),
        .in_memwrite  (in_memwrite),
        .in_addr      (in_addr),
        .in_wdata     (in_wdata),
        .in_rd        (in_rd),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_rd       (out_rd),
        .out_regwrite (out_regwrite),
        .fault        (fault),
        .stall        (stall)
    );

    always #5 clk = ~clk;

    // One op: rd_en/wr_en/addr/wdata/rd, number of REQ cycles before ack
    // (0 = no request expected), read data, and the expected result.
    typedef struct {
        logic        rd_en;
        logic        wr_en;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [4:0]  rd;
        int          delay;
        logic [63:0] rdata;
        logic [63:0] exp_data;
        logic        exp_regwrite;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_op(input vec_t v);
        in_valid    = 1'b1;
        in_memread  = v.rd_en;
        in_memwrite = v.wr_en;
        in_addr     = v.addr;
        in_wdata    = v.wdata;
        in_rd       = v.rd;
    endtask

    // Present op in IDLE, service the request, check the result pulse
    task automatic run_op(input vec_t v, input string tag);
        drive_op(v);
        #1;
        check({tag, ".in_ready"}, in_ready, 1);
        check({tag, ".stall_idle"}, stall, 0);
        @(posedge clk); #1;
        if (v.delay > 0) begin
            for (int k = 1; k <= v.delay; k++) begin
                check({tag, ".mem_req"}, mem_req, 1);
                check({tag, ".mem_we"}, mem_we, v.wr_en);
                check({tag, ".mem_addr"}, mem_addr, v.addr & 64'hFF);
                check({tag, ".mem_wdata"}, mem_wdata, v.wdata);
                check({tag, ".stall_req"}, stall, 1);
                check({tag, ".early_valid"}, out_valid, 0);
                if (k == v.delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = v.rdata;
                end
                @(posedge clk); #1;
                mem_ack   = 1'b0;
                mem_rdata = '0;
            end
        end else begin
            check({tag, ".no_req"}, mem_req, 0);
        end
        in_valid = 1'b0;
        check({tag, ".out_valid"}, out_valid, 1);
        check({tag, ".fault"}, fault, v.exp_fault);
        check({tag, ".regwrite"}, out_regwrite, v.exp_regwrite);
        check({tag, ".out_data"}, out_data, v.exp_data);
        if (!v.exp_fault && !v.wr_en) check({tag, ".out_rd"}, out_rd, v.rd);
        check({tag, ".req_done"}, mem_req, 0);
        @(posedge clk); #1;
        check({tag, ".valid_pulse"}, out_valid, 0);
        check({tag, ".fault_pulse"}, fault, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   n;

        //            rd    wr    addr                    wdata       rd     dly rdata                   exp_data                rw    flt
        vecs[0] = '{1'b1, 1'b0, 64'h05,                 64'h0,      5'd3,  1,  64'hDEAD_BEEF,          64'hDEAD_BEEF,          1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 64'hFF,                 64'h1234,   5'd7,  4,  64'h0,                  64'h0,                  1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 64'h77,                 64'h0,      5'd0,  0,  64'h0,                  64'h77,                 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 64'hAB,                 64'h0,      5'd9,  0,  64'h0,                  64'hAB,                 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 64'h100,                64'h0,      5'd2,  0,  64'h0,                  64'h0,                  1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 64'h10,                 64'h55,     5'd2,  0,  64'h0,                  64'h0,                  1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 64'h00,                 64'h0,      5'd0,  2,  64'h55,                 64'h55,                 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 64'hFF,                 64'h0,      5'd31, 3,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 64'h8000_0000_0000_0001, 64'hAA,    5'd1,  0,  64'h0,                  64'h0,                  1'b0, 1'b1};

        rst         = 1'b1;
        in_valid    = 1'b0;
        in_memread  = 1'b0;
        in_memwrite = 1'b0;
        in_addr     = '0;
        in_wdata    = '0;
        in_rd       = '0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst.mem_req", mem_req, 0);
        check("rst.out_valid", out_valid, 0);
        check("rst.fault", fault, 0);
        check("rst.out_data", out_data, 0);
        check("rst.mem_addr", mem_addr, 0);
        check("rst.in_ready", in_ready, 1);
        check("rst.stall", stall, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table of single ops
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Timeout: no ack, request must stay up exactly 16 cycles
        v = '{1'b1, 1'b0, 64'h10, 64'h0, 5'd4, 0, 64'h0, 64'h0, 1'b0, 1'b0};
        drive_op(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (mem_req === 1'b1 && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        check("to.req_cycles", 64'(n), 16);
        check("to.out_valid", out_valid, 1);
        check("to.fault", fault, 1);
        check("to.regwrite", out_regwrite, 0);
        check("to.out_data", out_data, 0);
        mem_ack   = 1'b1;
        mem_rdata = 64'h9999;
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        check("to.stray_valid", out_valid, 0);
        check("to.stray_fault", fault, 0);
        check("to.stray_req", mem_req, 0);
        check("to.stray_ready", in_ready, 1);

        // Ack on the 16th request cycle wins over the timeout
        v = '{1'b1, 1'b0, 64'h11, 64'h0, 5'd4, 0, 64'h0, 64'h0, 1'b0, 1'b0};
        drive_op(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            check($sformatf("ack16.req_c%0d", k), mem_req, 1);
            if (k == 16) begin
                mem_ack   = 1'b1;
                mem_rdata = 64'hCAFE;
            end
            @(posedge clk); #1;
        end
        mem_ack   = 1'b0;
        mem_rdata = '0;
        check("ack16.out_valid", out_valid, 1);
        check("ack16.fault", fault, 0);
        check("ack16.out_data", out_data, 64'hCAFE);
        check("ack16.regwrite", out_regwrite, 1);
        check("ack16.out_rd", out_rd, 4);
        check("ack16.req_done", mem_req, 0);
        @(posedge clk); #1;

        // Reset two cycles into REQ: request drops without a clock edge
        v = '{1'b1, 1'b0, 64'h33, 64'h0, 5'd5, 0, 64'h0, 64'h0, 1'b0, 1'b0};
        drive_op(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("rmid.req_before", mem_req, 1);
        rst = 1'b1;
        #1;
        check("rmid.req_async", mem_req, 0);
        check("rmid.ready_async", in_ready, 1);
        @(posedge clk); #1;
        rst     = 1'b0;
        mem_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            check($sformatf("rmid.no_valid%0d", k), out_valid, 0);
            check($sformatf("rmid.no_req%0d", k), mem_req, 0);
        end
        run_op(vecs[0], "rmid.after");

        // Back-to-back: next op accepted while the load result is pulsing
        v = '{1'b1, 1'b0, 64'h20, 64'h0, 5'd2, 0, 64'h0, 64'h0, 1'b0, 1'b0};
        drive_op(v);
        @(posedge clk); #1;
        v = '{1'b0, 1'b0, 64'h42, 64'h0, 5'd6, 0, 64'h0, 64'h0, 1'b0, 1'b0};
        drive_op(v);
        mem_ack   = 1'b1;
        mem_rdata = 64'h11;
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        check("b2b.load_valid", out_valid, 1);
        check("b2b.load_data", out_data, 64'h11);
        check("b2b.ready", in_ready, 1);
        check("b2b.stall", stall, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b.alu_valid", out_valid, 1);
        check("b2b.alu_data", out_data, 64'h42);
        check("b2b.alu_rd", out_rd, 6);
        check("b2b.alu_regwrite", out_regwrite, 1);
        check("b2b.alu_no_req", mem_req, 0);
        @(posedge clk); #1;
        check("b2b.idle_valid", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
